code_fetch: RTL and testbench
=============================

CODE_FETCH -- requirements
Module: code_fetch

Interface
REQ-001 Parameter DATA_WIDTH, default 32, instruction word width.
REQ-002 Parameter ADDR_WIDTH, default 8, code memory word-address width.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, byte PC fetched first after reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 mem_en  output  1  code memory read enable.
REQ-007 mem_addr  output  ADDR_WIDTH  code memory word address.
REQ-008 mem_dout  input  DATA_WIDTH  code memory read data, valid one cycle after a mem_en=1 cycle.
REQ-009 redirect_valid  input  1  discard all fetches; restart at redirect_pc.
REQ-010 redirect_pc  input  32  new byte PC; bits [1:0] ignored (treated as 0).
REQ-011 inst_valid  output  1  inst/inst_pc hold a valid instruction.
REQ-012 inst_ready  input  1  consumer accepts; transfer when inst_valid and inst_ready both 1.
REQ-013 inst  output  DATA_WIDTH  instruction word.
REQ-014 inst_pc  output  32  byte PC of inst.
REQ-015 inst_count  output  32  accepted-instruction counter (see Configuration).

Function
REQ-016 States: BOOT (first cycle after reset release, mem_en=0) -> RUN unconditionally; RUN persists until reset.
REQ-017 fetch_pc: 32-bit byte PC register; mem_addr = fetch_pc[ADDR_WIDTH+1:2], combinational from fetch_pc.
REQ-018 Output buffer: 2-entry FIFO of {inst, inst_pc}; inst_valid = buffer non-empty; inst/inst_pc = head entry, registered, no path from mem_dout.
REQ-019 inflight flag: set for the cycle after each issue; when set and not killed, {mem_dout, inflight_pc} is pushed into the buffer at end of that cycle.
REQ-020 Issue (mem_en=1) in RUN iff redirect_valid=0 and occupancy + inflight - pop < 2, pop = inst_valid & inst_ready; on issue fetch_pc += 4.
REQ-021 Steady state with inst_ready=1: one instruction per cycle, no bubbles.
REQ-022 Latency: issue in cycle N -> mem_dout in N+1 -> inst_valid with that word in N+2.
REQ-023 Buffer never overflows; mem_dout is never sampled in a cycle without inflight (memory returns 0 when disabled).
REQ-024 redirect_valid=1: buffer cleared, pending inflight data discarded, fetch_pc <= {redirect_pc[31:2],2'b00}, mem_en=0 that cycle; issue resumes next cycle.
REQ-025 Redirect -> first inst_valid with inst_pc=redirect_pc exactly 3 cycles later when inst_ready=1.
REQ-026 Redirect and pop in the same cycle: redirect wins; the popped entry counts as accepted; buffer empty next cycle.
REQ-027 inst_valid and inst/inst_pc stable while inst_valid=1 and inst_ready=0.
REQ-028 fetch_pc increments modulo 2^32; mem_addr wraps from all-ones to 0 with no special handling.
REQ-029 Redirect during BOOT is applied; BOOT still lasts exactly one cycle.

Reset
REQ-030 rst_n=0 asynchronously forces: state=BOOT, fetch_pc=RESET_PC, buffer empty, inflight=0, mem_en=0, inst_valid=0, inst=0, inst_pc=0, inst_count=0.
REQ-031 Reset mid-operation discards all buffered and inflight data; fetch restarts at RESET_PC.

Configuration
REQ-032 Macro FETCH_PERF_CNT_EN defined: inst_count increments by 1 on every accepted transfer, wraps modulo 2^32.
REQ-033 Macro FETCH_PERF_CNT_EN undefined: inst_count tied to 0, no counter logic; all other behaviour identical.

Verification
REQ-034 Memory words 0..3 = 11,22,33,44 hex, RESET_PC=0, inst_ready=1 -> inst 11,22,33,44 with inst_pc 0,4,8,C on consecutive cycles; first inst_valid 3 cycles after rst_n rises.
REQ-035 inst_ready=0 for 5 cycles mid-stream -> occupancy 2, mem_en=0, inst held stable; on release all words delivered in order, none lost or duplicated.
REQ-036 redirect_pc=0x41 while one fetch is inflight -> inflight word dropped; next inst_pc=0x40 three cycles later.
REQ-037 Buffer full, inst_ready=1 and redirect_valid=1 same cycle -> head accepted (inst_count+1 with macro), remaining entry flushed, next inst_pc=redirect target.
REQ-038 fetch_pc=0x3FC with ADDR_WIDTH=8 -> mem_addr 0xFF then 0x00; inst_pc 0x3FC then 0x400.
REQ-039 rst_n low for one cycle mid-stream with full buffer -> inst_valid=0 immediately, inst_count=0, refetch from RESET_PC.

Source files
------------

// File: rtl/code_fetch_if.sv
// Fetch-unit bundle: code-memory read port, redirect request and instruction stream.
// master = fetch unit, slave = memory/consumer side.
interface code_fetch_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  mem_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_dout;
    logic                  redirect_valid;
    logic [31:0]           redirect_pc;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [DATA_WIDTH-1:0] inst;
    logic [31:0]           inst_pc;
    logic [31:0]           inst_count;

    modport master (
        output mem_en, mem_addr, inst_valid, inst, inst_pc, inst_count,
        input  mem_dout, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  mem_en, mem_addr, inst_valid, inst, inst_pc, inst_count,
        output mem_dout, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/code_fetch.sv
// Instruction fetch: issues code-memory reads and buffers returned words in a 2-entry FIFO.
// Optional accepted-instruction counter enabled by defining FETCH_PERF_CNT_EN.
module code_fetch #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input logic         clk,
    input logic         rst_n,
    code_fetch_if.master bus
);
    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            state;
    logic [31:0]           fetch_pc;
    logic                  vld_p1;
    logic [31:0]           pc_p1;
    logic [DATA_WIDTH-1:0] buf_inst [2];
    logic [31:0]           buf_pc   [2];
    logic [1:0]            occ;
    logic                  pop;
    logic                  push;
    logic                  issue;
    logic [1:0]            occ_after_pop;

    assign pop           = (occ != 2'd0) && bus.inst_ready;
    assign push          = vld_p1 && !bus.redirect_valid;
    assign occ_after_pop = occ - {1'b0, pop};
    // Room check counts the word already in flight so the FIFO can never overflow.
    assign issue = (state == ST_RUN) && !bus.redirect_valid &&
                   ((occ_after_pop + {1'b0, vld_p1}) < 2'd2);

    assign bus.mem_en     = issue;
    assign bus.mem_addr   = fetch_pc[ADDR_WIDTH+1:2];
    assign bus.inst_valid = (occ != 2'd0);
    assign bus.inst       = buf_inst[0];
    assign bus.inst_pc    = buf_pc[0];

    // Stage 0: issue / PC sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_BOOT;
            fetch_pc <= RESET_PC;
            vld_p1   <= 1'b0;
            pc_p1    <= 32'h0;
            occ      <= 2'd0;
        end else begin
            state  <= ST_RUN;
            vld_p1 <= issue;
            if (issue) begin
                pc_p1 <= fetch_pc;
            end
            if (bus.redirect_valid) begin
                fetch_pc <= bus.redirect_pc & ~32'h3;
            end else if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            occ <= bus.redirect_valid ? 2'd0 : (occ_after_pop + {1'b0, push});
        end
    end

    // Stage 1: memory return into the output FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_inst[0] <= '0;
            buf_inst[1] <= '0;
            buf_pc[0]   <= 32'h0;
            buf_pc[1]   <= 32'h0;
        end else begin
            if (pop) begin
                buf_inst[0] <= buf_inst[1];
                buf_pc[0]   <= buf_pc[1];
            end
            if (push) begin
                buf_inst[occ_after_pop[0]] <= bus.mem_dout;
                buf_pc[occ_after_pop[0]]   <= pc_p1;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] acc_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt <= 32'h0;
        end else if (pop) begin
            acc_cnt <= acc_cnt + 32'd1;
        end
    end

    assign bus.inst_count = acc_cnt;
`else
    assign bus.inst_count = 32'h0;
`endif
endmodule

// File: tb/tb_code_fetch.sv
// Bench for code_fetch: memory model plus an in-order PC-stream reference with
// directed boot/stall/redirect/wrap/reset steps and a randomized phase.
module tb_code_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    code_fetch_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

    code_fetch #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(8),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [31:0] mem [256];

    // Synchronous-read code memory, returns 0 when not enabled.
    always @(posedge clk) bus.mem_dout <= bus.mem_en ? mem[bus.mem_addr] : 32'h0;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_pc;
    int unsigned n_acc;
    int          scnt = 0;
    int          mark_s;
    int          first_s;
    logic [31:0] first_pc;
    logic        prev_stall;
    logic [31:0] prev_inst;
    logic [31:0] prev_pc;
    logic        s_mem_en;
    logic [7:0]  s_mem_addr;
    int unsigned base;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt();
`ifdef FETCH_PERF_CNT_EN
        return n_acc;
`else
        return 32'h0;
`endif
    endfunction

    // One clock cycle: drive at negedge, sample 1 time unit later, return at next negedge.
    task automatic tick(input logic rdy, input logic rv, input logic [31:0] rpc);
        bus.inst_ready     = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        #1;
        s_mem_en   = bus.mem_en;
        s_mem_addr = bus.mem_addr;
        if (prev_stall) begin
            chk("hold_valid", bus.inst_valid, 1'b1);
            chk("hold_inst", bus.inst, prev_inst);
            chk("hold_pc", bus.inst_pc, prev_pc);
        end
        chk("inst_count", bus.inst_count, exp_cnt());
        if (rv) chk("redirect_mem_en", bus.mem_en, 1'b0);
        if (bus.inst_valid && first_s < 0) begin
            first_s  = scnt;
            first_pc = bus.inst_pc;
        end
        if (bus.inst_valid && rdy) begin
            chk("inst_pc", bus.inst_pc, exp_pc);
            chk("inst", bus.inst, mem[exp_pc[9:2]]);
            exp_pc = exp_pc + 32'd4;
            n_acc++;
        end
        prev_stall = bus.inst_valid && !rdy && !rv;
        prev_inst  = bus.inst;
        prev_pc    = bus.inst_pc;
        if (rv) begin
            exp_pc  = rpc & ~32'h3;
            mark_s  = scnt;
            first_s = -1;
        end
        scnt++;
        @(negedge clk);
    endtask

    task automatic run_until_valid(input string tag, input logic [31:0] target);
        for (int i = 0; i < 8 && first_s < 0; i++) tick(1'b1, 1'b0, 32'h0);
        chk({tag, "_latency"}, first_s - mark_s, 3);
        chk({tag, "_first_pc"}, first_pc, target);
    endtask

    task automatic model_reset();
        exp_pc     = RESET_PC;
        n_acc      = 0;
        prev_stall = 1'b0;
        mark_s     = scnt;
        first_s    = -1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        model_reset();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_inst_valid", bus.inst_valid, 1'b0);
        chk("rst_mem_en", bus.mem_en, 1'b0);
        chk("rst_inst", bus.inst, 32'h0);
        chk("rst_inst_pc", bus.inst_pc, 32'h0);
        chk("rst_inst_count", bus.inst_count, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Boot stream 11,22,33,44 then steady state without bubbles
        run_until_valid("boot", RESET_PC);
        base = n_acc;
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 32'h0);
        chk("no_bubble", n_acc - base, 20);

        // Consumer stall: buffer fills, issue stops, head held
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 32'h0);
        chk("stall_mem_en", s_mem_en, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 32'h0);

        // Redirect with a fetch in flight; low bits ignored
        tick(1'b1, 1'b1, 32'h41);
        run_until_valid("redir41", 32'h40);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 32'h0);

        // Full buffer, pop and redirect in the same cycle
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'h0);
        base = n_acc;
        tick(1'b1, 1'b1, 32'h80);
        chk("pop_on_redirect", n_acc - base, 1);
        run_until_valid("redir80", 32'h80);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 32'h0);

        // Word-address wrap
        tick(1'b1, 1'b1, 32'h3FC);
        tick(1'b1, 1'b0, 32'h0);
        chk("wrap_en0", s_mem_en, 1'b1);
        chk("wrap_addr0", s_mem_addr, 8'hFF);
        tick(1'b1, 1'b0, 32'h0);
        chk("wrap_addr1", s_mem_addr, 8'h00);
        run_until_valid("wrap", 32'h3FC);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 32'h0);

        // 32-bit PC wrap
        tick(1'b1, 1'b1, 32'hFFFF_FFF8);
        run_until_valid("pc32wrap", 32'hFFFF_FFF8);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0), $urandom);
        end

        // Reset mid-stream with a full buffer
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("midrst_inst_valid", bus.inst_valid, 1'b0);
        chk("midrst_inst_count", bus.inst_count, 32'h0);
        chk("midrst_mem_en", bus.mem_en, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run_until_valid("midrst", RESET_PC);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 32'h0);

        // Redirect during the boot cycle
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tick(1'b1, 1'b1, 32'h20);
        run_until_valid("bootredir", 32'h20);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
